// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: real-time client state and arbiter FSM encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    READY    = 2'd1,
    ACTIVE   = 2'd2
  } rt_state_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Encoding 2'b11 is deliberately not live.
  function automatic logic rt_is_live(input logic [1:0] s);
    return (s == READY) || (s == ACTIVE);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or above ptr_i, wrapping at N.
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] winner_o,
  output logic                 valid_o
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[idx]) begin
        winner_o = IW'(idx);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-client arbiter for the shared memory port: real-time client override plus
// round-robin among the rest with a per-grant transfer quantum.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned RT_CLIENT   = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned QUANTUM     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    rt_state,
  input  logic [NUM_CLIENTS-1:0]        cli_write,
  input  logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_adr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
  input  logic [NUM_CLIENTS*SEL_W-1:0]  cli_sel,
  output logic [NUM_CLIENTS-1:0]        cli_grant,
  output logic [NUM_CLIENTS-1:0]        cli_ack,
  output logic [DATA_W-1:0]             cli_rdata,
  output logic                          write_to_mem,
  output logic                          read_to_mem,
  output logic [ADDR_W-1:0]             adr_to_mem,
  output logic [DATA_W-1:0]             data_to_mem,
  output logic [SEL_W-1:0]              sel_to_mem,
  input  logic [DATA_W-1:0]             data_from_mem,
  input  logic                          mem_busy
);

  localparam int unsigned IW = $clog2(NUM_CLIENTS);
  localparam int unsigned CW = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QMAX  = CW'(QUANTUM);
  localparam logic [CW-1:0] QLAST = CW'(QUANTUM - 1);
  localparam logic [IW-1:0] RT_IDX   = IW'(RT_CLIENT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLIENTS - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [IW-1:0]          pick_winner;
  logic                   pick_valid;
  logic                   rt_live, owner_req, owner_ack, rt_exempt, spent, preempt, decide;

  assign req       = cli_read | cli_write;
  assign cli_rdata = data_from_mem;
  assign rt_live   = rt_is_live(rt_state);

  rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  always_comb begin
    cli_grant    = '0;
    write_to_mem = 1'b0;
    read_to_mem  = 1'b0;
    adr_to_mem   = '0;
    data_to_mem  = '0;
    sel_to_mem   = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (state_q == OWN && owner_q == IW'(i)) begin
        cli_grant[i] = 1'b1;
        write_to_mem = cli_write[i];
        read_to_mem  = cli_read[i];
        adr_to_mem   = cli_adr[i*ADDR_W +: ADDR_W];
        data_to_mem  = cli_wdata[i*DATA_W +: DATA_W];
        sel_to_mem   = cli_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign cli_ack   = cli_grant & req & {NUM_CLIENTS{~mem_busy}};
  assign owner_req = |(cli_grant & req);
  assign owner_ack = |cli_ack;
  assign rt_exempt = (owner_q == RT_IDX) && rt_live;
  assign spent     = owner_ack && !rt_exempt && (cnt_q >= QLAST);
  assign preempt   = rt_live && (owner_q != RT_IDX);
  assign decide    = (state_q == IDLE) ||
                     (!mem_busy && (!owner_req || spent || preempt));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (decide) begin
      cnt_d = '0;
      if (rt_live) begin
        state_d = OWN;
        owner_d = RT_IDX;
      end else if (pick_valid) begin
        // An expired owner hands over through one idle cycle; a sole requester is re-granted directly.
        if (state_q == OWN && spent && pick_winner != owner_q) begin
          state_d = IDLE;
        end else begin
          state_d = OWN;
          owner_d = pick_winner;
          ptr_d   = (pick_winner == LAST_IDX) ? '0 : pick_winner + IW'(1);
        end
      end else begin
        state_d = IDLE;
      end
    end else if (owner_ack && cnt_q != QMAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (QUANTUM=4): expected acks are queued by the stimulus and
// matched by a negedge monitor against cycle, ack vector, address and read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rt_state;
  logic [2:0]  cli_write, cli_read;
  logic [95:0] cli_adr, cli_wdata;
  logic [11:0] cli_sel;
  logic [2:0]  cli_grant, cli_ack;
  logic [31:0] cli_rdata;
  logic        write_to_mem, read_to_mem;
  logic [31:0] adr_to_mem, data_to_mem;
  logic [3:0]  sel_to_mem;
  logic [31:0] data_from_mem;
  logic        mem_busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  ack;
    logic [31:0] adr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign data_from_mem = 32'hA500_0000 ^ 32'(cyc);

  mem_arbiter #(
    .NUM_CLIENTS (3),
    .RT_CLIENT   (1),
    .ADDR_W      (32),
    .DATA_W      (32),
    .SEL_W       (4),
    .QUANTUM     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rt_state      (rt_state),
    .cli_write     (cli_write),
    .cli_read      (cli_read),
    .cli_adr       (cli_adr),
    .cli_wdata     (cli_wdata),
    .cli_sel       (cli_sel),
    .cli_grant     (cli_grant),
    .cli_ack       (cli_ack),
    .cli_rdata     (cli_rdata),
    .write_to_mem  (write_to_mem),
    .read_to_mem   (read_to_mem),
    .adr_to_mem    (adr_to_mem),
    .data_to_mem   (data_to_mem),
    .sel_to_mem    (sel_to_mem),
    .data_from_mem (data_from_mem),
    .mem_busy      (mem_busy)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endfunction

  function automatic logic [31:0] adr_of(input int cl);
    return 32'h1000 + 32'(16 * cl);
  endfunction

  task automatic push(input int c, input int cl, input logic [31:0] a);
    exp_t e;
    e.cyc = c;
    e.ack = '0;
    e.ack[cl] = 1'b1;
    e.adr = a;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && cli_ack != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(cli_ack), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        check("ack_vec", 64'(cli_ack), 64'(e.ack));
        check("ack_adr", 64'(adr_to_mem), 64'(e.adr));
        check("ack_rdata", 64'(cli_rdata), 64'(32'hA500_0000 ^ 32'(cyc)));
      end
    end
  end

  initial begin
    int c;
    rst       = 1'b1;
    rt_state  = 2'd0;
    cli_write = '0;
    cli_read  = '0;
    cli_adr   = {adr_of(2), adr_of(1), adr_of(0)};
    cli_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    cli_sel   = 12'hFFF;
    mem_busy  = 1'b0;
    #2;
    check("rst_grant", 64'(cli_grant), 64'd0);
    check("rst_ack", 64'(cli_ack), 64'd0);
    check("rst_rd", 64'(read_to_mem), 64'd0);
    check("rst_wr", 64'(write_to_mem), 64'd0);
    check("rst_adr", 64'(adr_to_mem), 64'd0);
    tick(2);
    rst = 1'b0;

    // Clients 0 and 2 alternate, 4 acks each, one idle cycle per handover.
    tick(1);
    c = cyc;
    cli_read = 3'b101;
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++)
        push(c + 1 + 5 * g + b, (g % 2 == 1) ? 2 : 0, adr_of((g % 2 == 1) ? 2 : 0));
    tick(5);
    check("handover_gap", 64'(cli_grant), 64'd0);
    tick(15);
    cli_read = '0;

    // Sole requester: back-to-back acks across quantum boundaries.
    tick(2);
    c = cyc;
    cli_read = 3'b100;
    for (int b = 1; b <= 10; b++) push(c + b, 2, adr_of(2));
    tick(11);
    cli_read = '0;

    // RT preemption deferred by mem_busy, then RT keeps the bus past the quantum.
    tick(2);
    c = cyc;
    cli_read = 3'b001;
    push(c + 1, 0, adr_of(0));
    push(c + 2, 0, adr_of(0));
    tick(3);
    mem_busy = 1'b1;
    rt_state = 2'd1;
    cli_read = 3'b011;
    for (int k = 0; k < 3; k++) begin
      check("busy_hold_grant", 64'(cli_grant), 64'b001);
      tick(1);
    end
    mem_busy = 1'b0;
    push(c + 6, 0, adr_of(0));
    for (int b = 7; b <= 26; b++) push(c + b, 1, adr_of(1));
    check("busy_release_grant", 64'(cli_grant), 64'b001);
    tick(1);
    check("rt_grant", 64'(cli_grant), 64'b010);
    rt_state = 2'd2;
    tick(20);
    rt_state = 2'd0;
    cli_read = '0;
    tick(1);
    check("idle_after_rt", 64'(cli_grant), 64'd0);

    // Write held under mem_busy for 5 cycles.
    c = cyc;
    cli_adr[31:0]   = 32'h0000_0100;
    cli_wdata[31:0] = 32'hDEAD_BEEF;
    cli_sel[3:0]    = 4'b0011;
    cli_write       = 3'b001;
    mem_busy        = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("hold_wr", 64'(write_to_mem), 64'd1);
      check("hold_adr", 64'(adr_to_mem), 64'h100);
      check("hold_data", 64'(data_to_mem), 64'hDEAD_BEEF);
      check("hold_sel", 64'(sel_to_mem), 64'b0011);
    end
    tick(1);
    mem_busy = 1'b0;
    push(c + 6, 0, 32'h0000_0100);
    tick(1);
    cli_write = '0;

    // All requests gone: idle with quiet strobes, then a late request from client 1.
    tick(1);
    check("idle_grant", 64'(cli_grant), 64'd0);
    check("idle_wr", 64'(write_to_mem), 64'd0);
    check("idle_rd", 64'(read_to_mem), 64'd0);
    tick(3);
    c = cyc;
    cli_read = 3'b010;
    push(c + 1, 1, adr_of(1));
    tick(1);
    check("late_grant", 64'(cli_grant), 64'b010);

    // Asynchronous reset in the middle of a read, between clock edges.
    tick(1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_grant", 64'(cli_grant), 64'd0);
    check("async_rst_rd", 64'(read_to_mem), 64'd0);
    check("async_rst_ack", 64'(cli_ack), 64'd0);
    tick(2);
    cli_read = '0;
    rst = 1'b0;

    tick(3);
    check("pending_acks", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
